// File: rtl/window_gen_2d.sv
// Streaming MATRIX_SIZE_V x MATRIX_SIZE_H sliding-window generator with cascaded line memories.
// Optional macro WINDOW_ZERO_PAD_EN: emit a window for every pixel, zero-filling out-of-frame taps.
module window_gen_2d #(
  parameter int MATRIX_SIZE_H   = 7,
  parameter int MATRIX_SIZE_V   = 7,
  parameter int BITS_PER_SYMBOL = 8,
  parameter int LINE_WIDTH      = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int ENA_ON          = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BITS_PER_SYMBOL-1:0] din_data_i,
  input  logic                       din_valid_i,
  input  logic                       din_sop_i,
  output logic [BITS_PER_SYMBOL-1:0] dout_window_o [MATRIX_SIZE_V-1:0][MATRIX_SIZE_H-1:0],
  output logic                       dout_valid_o,
  output logic                       dout_sop_o,
  output logic                       dout_eof_o
);

  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(MATRIX_SIZE_H - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(MATRIX_SIZE_V - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CW-1:0]              r_col, w_col;
  logic [RW-1:0]              r_row, w_row;
  logic                       w_en, w_accept, w_last, w_win_ok, w_first;
  logic [BITS_PER_SYMBOL-1:0] r_mem    [MATRIX_SIZE_V-1][LINE_WIDTH];
  logic [BITS_PER_SYMBOL-1:0] w_lm_rd  [MATRIX_SIZE_V-1];
  logic [BITS_PER_SYMBOL-1:0] w_tap_in [MATRIX_SIZE_V];
  logic [BITS_PER_SYMBOL-1:0] r_win    [MATRIX_SIZE_V-1:0][MATRIX_SIZE_H-1:0];
  logic                       r_valid, r_sop, r_eof;

  // A sop pixel is always taken as (0,0), whether it starts or restarts a frame.
  always_comb begin
    w_en        = (ENA_ON != 0) ? din_valid_i : 1'b1;
    w_accept    = w_en && ((r_state == ACTIVE) || din_sop_i);
    w_col       = din_sop_i ? '0 : r_col;
    w_row       = din_sop_i ? '0 : r_row;
    w_last      = (w_row == ROW_LAST) && (w_col == COL_LAST);
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_last ? IDLE : ACTIVE;
  end

  always_comb begin
`ifdef WINDOW_ZERO_PAD_EN
    w_win_ok = 1'b1;
    w_first  = (w_row == '0) && (w_col == '0);
`else
    w_win_ok = (w_row >= ROW_FULL) && (w_col >= COL_FULL);
    w_first  = (w_row == ROW_FULL) && (w_col == COL_FULL);
`endif
  end

  // Memory k holds the line k+1 rows above the current one; reads see pre-write contents.
  always_comb begin
    for (int k = 0; k < MATRIX_SIZE_V - 1; k++) w_lm_rd[k] = r_mem[k][w_col];
    w_tap_in[MATRIX_SIZE_V-1] = din_data_i;
    for (int v = 0; v < MATRIX_SIZE_V - 1; v++) begin
      w_tap_in[v] = w_lm_rd[MATRIX_SIZE_V-2-v];
`ifdef WINDOW_ZERO_PAD_EN
      if (w_row < RW'(MATRIX_SIZE_V - 1 - v)) w_tap_in[v] = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[0][w_col] <= din_data_i;
      for (int k = 1; k < MATRIX_SIZE_V - 1; k++) r_mem[k][w_col] <= w_lm_rd[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_last) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int v = 0; v < MATRIX_SIZE_V; v++)
        for (int h = 0; h < MATRIX_SIZE_H; h++) r_win[v][h] <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eof   <= 1'b0;
      if (w_accept) begin
        for (int v = 0; v < MATRIX_SIZE_V; v++) begin
          for (int h = 0; h < MATRIX_SIZE_H - 1; h++) begin
`ifdef WINDOW_ZERO_PAD_EN
            // At col 0 every older tap would point left of the frame.
            r_win[v][h] <= (w_col == '0) ? '0 : r_win[v][h+1];
`else
            r_win[v][h] <= r_win[v][h+1];
`endif
          end
          r_win[v][MATRIX_SIZE_H-1] <= w_tap_in[v];
        end
        r_valid <= w_win_ok;
        r_sop   <= w_first;
        r_eof   <= w_last;
      end
    end
  end

  assign dout_window_o = r_win;
  assign dout_valid_o  = r_valid;
  assign dout_sop_o    = r_sop;
  assign dout_eof_o    = r_eof;

endmodule

// File: tb/tb_window_gen_2d.sv
// Directed bench for window_gen_2d on a 4x4 frame with a 3x3 window.
// Builds either way; with WINDOW_ZERO_PAD_EN defined it expects zero-padded windows.
module tb_window_gen_2d;
  localparam int H = 3, V = 3, B = 8, LW = 4, FH = 4;
  typedef logic [127:0] val_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [B-1:0] din_data_i;
  logic         din_valid_i, din_sop_i;
  logic [B-1:0] dout_window_o [V-1:0][H-1:0];
  logic         dout_valid_o, dout_sop_o, dout_eof_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [71:0] q_win[$];
  bit          q_sop[$];
  bit          q_eof[$];

  window_gen_2d #(
    .MATRIX_SIZE_H(H), .MATRIX_SIZE_V(V), .BITS_PER_SYMBOL(B),
    .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .ENA_ON(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .din_data_i(din_data_i), .din_valid_i(din_valid_i), .din_sop_i(din_sop_i),
    .dout_window_o(dout_window_o), .dout_valid_o(dout_valid_o),
    .dout_sop_o(dout_sop_o), .dout_eof_o(dout_eof_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] flat_win();
    logic [71:0] w;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) w[(v*H+h)*8 +: 8] = dout_window_o[v][h];
    return w;
  endfunction

  // Tap [v][h] of the window at (r,c) is pixel (r-2+v, c-2+h), value row*4+col+1, 0 if outside.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    int rr, cc;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) begin
        rr = r - (V-1) + v;
        cc = c - (H-1) + h;
        w[(v*H+h)*8 +: 8] = (rr < 0 || cc < 0) ? 8'd0 : 8'(rr*LW + cc + 1);
      end
    return w;
  endfunction

  always @(posedge clk_i) begin
    logic v_in;
    v_in = din_valid_i;
    #1;
    if (!v_in) check("valid_after_idle", dout_valid_o, 1'b0);
    if (dout_valid_o) begin
      q_win.push_back(flat_win());
      q_sop.push_back(dout_sop_o);
      q_eof.push_back(dout_eof_o);
    end
  end

  task automatic drive(input logic [B-1:0] d, input logic v, input logic s);
    @(negedge clk_i);
    din_data_i  = d;
    din_valid_i = v;
    din_sop_i   = s;
  endtask

  task automatic clear_q();
    q_win.delete();
    q_sop.delete();
    q_eof.delete();
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) begin
        drive(8'(r*LW + c + 1), 1'b1, (r == 0) && (c == 0));
        if (gaps) drive(8'd0, 1'b0, 1'b0);
      end
    drive(8'd0, 1'b0, 1'b0);
    drive(8'd0, 1'b0, 1'b0);
  endtask

  task automatic verify_frame(input string tag);
    int r0, c0, n, idx;
`ifdef WINDOW_ZERO_PAD_EN
    r0 = 0; c0 = 0; n = LW*FH;
`else
    r0 = V-1; c0 = H-1; n = (FH-V+1)*(LW-H+1);
`endif
    check({tag, "_count"}, q_win.size(), n);
    idx = 0;
    for (int r = r0; r < FH; r++)
      for (int c = c0; c < LW; c++) begin
        if (idx < q_win.size()) begin
          check($sformatf("%s_win_%0d_%0d", tag, r, c), q_win[idx], exp_win(r, c));
          check($sformatf("%s_sop_%0d_%0d", tag, r, c), q_sop[idx], (r == r0) && (c == c0));
          check($sformatf("%s_eof_%0d_%0d", tag, r, c), q_eof[idx], (r == FH-1) && (c == LW-1));
        end
        idx++;
      end
    if (q_win.size() > 5) begin
`ifdef WINDOW_ZERO_PAD_EN
      check({tag, "_first"}, q_win[0],
            {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      check({tag, "_win_1_1"}, q_win[5],
            {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
`else
      check({tag, "_first"}, q_win[0],
            {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
`endif
    end
    if (q_win.size() > 0) begin
      check({tag, "_last"}, q_win[q_win.size()-1],
            {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6});
      check({tag, "_last_eof"}, q_eof[q_eof.size()-1], 1'b1);
    end
    clear_q();
  endtask

  function automatic int count_eof();
    int n = 0;
    foreach (q_eof[i]) if (q_eof[i]) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    din_data_i  = '0;
    din_valid_i = 1'b0;
    din_sop_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", dout_valid_o, 1'b0);
    check("rst_sop", dout_sop_o, 1'b0);
    check("rst_eof", dout_eof_o, 1'b0);
    check("rst_window", flat_win(), 72'd0);
    rst_i = 1'b0;
    clear_q();

    send_frame(1'b0);
    verify_frame("cont");

    send_frame(1'b1);
    verify_frame("gaps");

    for (int i = 0; i < 5; i++) drive(8'(100 + i), 1'b1, 1'b0);
    drive(8'd0, 1'b0, 1'b0);
    check("presop_count", q_win.size(), 0);
    clear_q();
    send_frame(1'b0);
    verify_frame("presop");

    // Abort after (2,0); the restart sop lands where (2,1) would be.
    for (int i = 0; i < 9; i++) drive(8'(i + 1), 1'b1, i == 0);
    drive(8'd0, 1'b0, 1'b0);
`ifdef WINDOW_ZERO_PAD_EN
    check("abort_count", q_win.size(), 9);
`else
    check("abort_count", q_win.size(), 0);
`endif
    check("abort_eof", count_eof(), 0);
    clear_q();
    send_frame(1'b0);
    verify_frame("restart");

    for (int i = 0; i < 11; i++) drive(8'(i + 1), 1'b1, i == 0);
    @(posedge clk_i);
    #2;
    check("prerst_valid", dout_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("arst_valid", dout_valid_o, 1'b0);
    check("arst_sop", dout_sop_o, 1'b0);
    check("arst_window", flat_win(), 72'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_q();
    for (int i = 0; i < 4; i++) drive(8'(50 + i), 1'b1, 1'b0);
    drive(8'd0, 1'b0, 1'b0);
    check("postrst_nosop_count", q_win.size(), 0);
    clear_q();
    send_frame(1'b0);
    verify_frame("postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
